// File: rtl/pc_regfile_state_pkg.sv
// Shared constants and types for the architectural state block
// (program counter plus integer register file).
package pc_regfile_state_pkg;

    localparam int          ADDR_WIDTH_DEF = 5;
    localparam int          DATA_WIDTH_DEF = 32;
    localparam logic [31:0] PC_RESET_DEF   = 32'h8000_0000;

    typedef logic [DATA_WIDTH_DEF-1:0] word_t;

endpackage : pc_regfile_state_pkg

// File: rtl/pc_regfile_state_if.sv
// Bundle of the PC and register-file signals exchanged between the
// core datapath (master) and the architectural state block (slave).
// There is no valid/ready handshake here: the PC load is qualified by
// pc_wen and the register write by rf_wen, both sampled on the rising
// clock edge; the read port is a pure combinational lookup.
interface pc_regfile_state_if
    import pc_regfile_state_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic [DATA_WIDTH-1:0] pc_din;
    logic                  pc_wen;
    logic [DATA_WIDTH-1:0] pc_dout;
    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic [ADDR_WIDTH-1:0] rf_raddr;
    logic [DATA_WIDTH-1:0] rf_rdata;

    // Datapath side: drives next-PC and write/read requests.
    modport master (
        output pc_din, pc_wen, rf_wen, rf_waddr, rf_wdata, rf_raddr,
        input  pc_dout, rf_rdata
    );

    // State block side: holds PC and registers, returns read data.
    modport slave (
        input  pc_din, pc_wen, rf_wen, rf_waddr, rf_wdata, rf_raddr,
        output pc_dout, rf_rdata
    );

endinterface : pc_regfile_state_if

// File: rtl/pc_regfile_state_state_reg.sv
// Generic enable-gated register with an asynchronous active-high reset
// to a parameterised value. Used for the PC and every register entry.
module state_reg
    import pc_regfile_state_pkg::*;
#(
    parameter int               WIDTH     = DATA_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] dout_d;
    logic [WIDTH-1:0] dout_q;

    // Next value: load din when enabled, otherwise hold.
    always_comb begin
        dout_d = dout_q;
        if (wen) begin
            dout_d = din;
        end
    end

    // Storage flop; reset takes effect immediately, without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= RESET_VAL;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule : state_reg

// File: rtl/pc_regfile_state.sv
// Architectural state of the single-cycle core: the program counter and
// the integer register file (one synchronous write port, one
// combinational read port, entry 0 hardwired to zero).
module pc_regfile_state
    import pc_regfile_state_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] PC_RESET   = PC_RESET_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    pc_regfile_state_if.slave    bus
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    // One decoded write enable per writable entry; entry 0 has none.
    logic [NUM_REGS-1:1]   rf_we;
    logic [DATA_WIDTH-1:0] rf_entry [NUM_REGS];

    // PC: plain enable-gated register; the increment is the caller's job.
    state_reg #(
        .WIDTH     (DATA_WIDTH),
        .RESET_VAL (PC_RESET)
    ) u_pc (
        .clk  (clk),
        .rst  (rst),
        .wen  (bus.pc_wen),
        .din  (bus.pc_din),
        .dout (bus.pc_dout)
    );

    // Write-address decode, gated by rf_wen so a disabled write never
    // lets an undefined address reach any entry.
    always_comb begin
        rf_we = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            rf_we[i] = bus.rf_wen && (bus.rf_waddr == ADDR_WIDTH'(i));
        end
    end

    // x0 is a constant, so writes to address 0 simply have nowhere to go.
    assign rf_entry[0] = '0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_rf
        state_reg #(
            .WIDTH     (DATA_WIDTH),
            .RESET_VAL ('0)
        ) u_entry (
            .clk  (clk),
            .rst  (rst),
            .wen  (rf_we[g]),
            .din  (bus.rf_wdata),
            .dout (rf_entry[g])
        );
    end

    // Combinational read of the stored value; no write-to-read bypass,
    // so a same-cycle write becomes visible only after the edge.
    assign bus.rf_rdata = rf_entry[bus.rf_raddr];

endmodule : pc_regfile_state

// File: tb/tb_pc_regfile_state.sv
// Self-checking bench for pc_regfile_state: directed checks for reset,
// PC stepping/holding, x0 behaviour, write enable and async reset,
// followed by randomized traffic against a behavioural model.
module tb_pc_regfile_state;
    import pc_regfile_state_pkg::*;

    localparam int    AW       = ADDR_WIDTH_DEF;
    localparam int    DW       = DATA_WIDTH_DEF;
    localparam int    NREG     = 1 << AW;
    localparam word_t PC_RESET = PC_RESET_DEF;

    logic clk;
    logic rst;
    logic clk_en;

    pc_regfile_state_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    pc_regfile_state #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .PC_RESET   (PC_RESET)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock is held low until the bench enables it, so the reset checks
    // at time zero happen with no edge at all.
    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    // Behavioural model of the architectural state.
    word_t model_pc;
    word_t model_rf [NREG];

    int n_vec;
    int n_err;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        model_pc = PC_RESET;
        for (int i = 0; i < NREG; i++) model_rf[i] = '0;
    endtask

    // Drive one cycle of inputs, check the pre-edge read (old value),
    // take the edge, update the model and check post-edge state.
    task automatic apply(input logic pwen, input word_t pdin,
                         input logic wen, input logic [AW-1:0] wa,
                         input word_t wd, input logic [AW-1:0] ra);
        bus.pc_wen   = pwen;
        bus.pc_din   = pdin;
        bus.rf_wen   = wen;
        bus.rf_waddr = wa;
        bus.rf_wdata = wd;
        bus.rf_raddr = ra;
        #1;
        check("rd_pre", bus.rf_rdata, model_rf[ra]);
        check("pc_pre", bus.pc_dout, model_pc);
        @(posedge clk);
        if (pwen) model_pc = pdin;
        if (wen && wa != 0) model_rf[wa] = wd;
        #1;
        check("pc_post", bus.pc_dout, model_pc);
        check("rd_post", bus.rf_rdata, model_rf[ra]);
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] ra, input word_t exp);
        bus.rf_raddr = ra;
        #1;
        check(tag, bus.rf_rdata, exp);
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        clk_en = 1'b0;
        bus.pc_wen   = 1'b0;
        bus.pc_din   = '0;
        bus.rf_wen   = 1'b0;
        bus.rf_waddr = '0;
        bus.rf_wdata = '0;
        bus.rf_raddr = '0;
        model_reset();

        // Reset with no clock edge: PC and every entry take reset values.
        rst = 1'b1;
        #1;
        check("rst_pc", bus.pc_dout, 32'h8000_0000);
        for (int i = 0; i < NREG; i++) read_check("rst_rf", AW'(i), 32'h0);

        // Start the clock, release reset away from an edge.
        clk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // PC steps by 4 four times, then holds for two edges.
        for (int i = 0; i < 4; i++) apply(1'b1, model_pc + 32'd4, 1'b0, '0, '0, '0);
        check("pc_step4", bus.pc_dout, 32'h8000_0010);
        for (int i = 0; i < 2; i++) apply(1'b0, 32'hFFFF_FFF0, 1'b0, '0, '0, '0);
        check("pc_hold", bus.pc_dout, 32'h8000_0010);

        // Write x1 while reading it: old value before, new after.
        apply(1'b0, '0, 1'b1, AW'(1), 32'h0000_0005, AW'(1));
        check("x1_val", bus.rf_rdata, 32'h0000_0005);
        apply(1'b0, '0, 1'b1, AW'(2), 32'hDEAD_BEEF, AW'(1));
        check("x1_keep", bus.rf_rdata, 32'h0000_0005);
        read_check("x2_val", AW'(2), 32'hDEAD_BEEF);

        // Writes to x0 are discarded.
        apply(1'b0, '0, 1'b1, AW'(0), 32'hFFFF_FFFF, AW'(0));
        check("x0_zero", bus.rf_rdata, 32'h0);

        // rf_wen gates the write.
        apply(1'b0, '0, 1'b0, AW'(31), 32'h1234_5678, AW'(31));
        check("x31_nowen", bus.rf_rdata, 32'h0);
        apply(1'b0, '0, 1'b1, AW'(31), 32'h1234_5678, AW'(31));
        check("x31_wen", bus.rf_rdata, 32'h1234_5678);

        // Mid-run async reset, with a PC load and a write pending.
        apply(1'b1, 32'h8000_0020, 1'b1, AW'(5), 32'hA5A5_A5A5, AW'(5));
        check("x5_set", bus.rf_rdata, 32'hA5A5_A5A5);
        bus.pc_wen   = 1'b1;
        bus.pc_din   = 32'h0000_1234;
        bus.rf_wen   = 1'b1;
        bus.rf_waddr = AW'(5);
        bus.rf_wdata = 32'hFFFF_0000;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("arst_pc", bus.pc_dout, 32'h8000_0000);
        check("arst_x5", bus.rf_rdata, 32'h0);
        @(posedge clk);
        #1;
        check("arst_pc_edge", bus.pc_dout, 32'h8000_0000);
        check("arst_x5_edge", bus.rf_rdata, 32'h0);
        read_check("arst_x31", AW'(31), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        apply(1'b1, 32'h8000_0004, 1'b1, AW'(5), 32'h0BAD_F00D, AW'(5));
        check("resume_x5", bus.rf_rdata, 32'h0BAD_F00D);
        check("resume_pc", bus.pc_dout, 32'h8000_0004);

        // Randomized traffic; reads often target the write address.
        for (int n = 0; n < 400; n++) begin
            logic          pwen;
            logic          wen;
            logic [AW-1:0] wa;
            logic [AW-1:0] ra;
            pwen = 1'($urandom_range(0, 1));
            wen  = ($urandom_range(0, 3) != 0);
            wa   = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(0, NREG - 1));
            ra   = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, NREG - 1));
            apply(pwen, word_t'($urandom), wen, wa, word_t'($urandom), ra);
        end

        // Final sweep of the whole file against the model.
        for (int i = 0; i < NREG; i++) read_check("final_rf", AW'(i), model_rf[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pc_regfile_state
